current_block_buffer: RTL

- Downstream of the 2-to-32 pixel serial-to-parallel stage.
- Captures each completed 256-bit current-block row (flagged by curr_ready_32) into a ping-pong pair of 32x32-pixel banks.
- Streams full blocks, one row per cycle, to the SAD/PE array under a valid/ready handshake.
- Exports an accept flag so the current-pixel controller can throttle in_curr_enable.

---
 rtl/current_block_buffer_if.sv | 33 +++
 rtl/current_block_buffer.sv | 117 +++++++++++
 2 files changed

// File: rtl/current_block_buffer_if.sv
// Bundle of the row-capture and row-streaming signals of current_block_buffer.
// The master side is the environment (upstream row source and downstream PE array).
interface current_block_buffer_if #(
  parameter int PIXEL = 8,
  parameter int X     = 32,
  parameter int ROWS  = 32
);
  localparam int RW = PIXEL * X;
  localparam int IW = $clog2(ROWS);

  logic [RW-1:0] current_pixels;
  logic          curr_ready_32;
  logic          curr_accept;
  logic [RW-1:0] row_out;
  logic          row_out_valid;
  logic          row_out_ready;
  logic [IW-1:0] row_out_idx;
  logic          row_out_last;
  logic          blk_done;
  logic          overflow;

  modport master (
    output current_pixels, curr_ready_32, row_out_ready,
    input  curr_accept, row_out, row_out_valid, row_out_idx,
           row_out_last, blk_done, overflow
  );

  modport slave (
    input  current_pixels, curr_ready_32, row_out_ready,
    output curr_accept, row_out, row_out_valid, row_out_idx,
           row_out_last, blk_done, overflow
  );
endinterface

// File: rtl/current_block_buffer.sv
// Ping-pong buffer of two 32-row current blocks: rows are captured on the rising
// edge of curr_ready_32 and whole blocks are streamed out one row per handshake.
module current_block_buffer #(
  parameter int PIXEL = 8,
  parameter int X     = 32,
  parameter int ROWS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  current_block_buffer_if.slave bus
);
  localparam int RW = PIXEL * X;
  localparam int IW = $clog2(ROWS);
  localparam logic [IW-1:0] LAST_ROW = IW'(ROWS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state_q, state_d;
  logic          ready_dly_q, ready_dly_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_row_q, wr_row_d;
  logic [IW-1:0] rd_row_q, rd_row_d;
  logic [1:0]    full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          blk_done_q, blk_done_d;

  logic [RW-1:0] mem_q [2][ROWS];

  logic cap, wr_en, xfer, xfer_last;

  always_comb begin
    cap       = bus.curr_ready_32 & ~ready_dly_q;
    wr_en     = cap & ~full_q[wr_bank_q];
    xfer      = (state_q == STREAM) & bus.row_out_ready;
    xfer_last = xfer & (rd_row_q == LAST_ROW);

    ready_dly_d = bus.curr_ready_32;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_row_d    = wr_row_q;
    rd_row_d    = rd_row_q;
    full_d      = full_q;
    overflow_d  = overflow_q;
    blk_done_d  = xfer_last;
    state_d     = state_q;

    // A row arriving at a full write bank is dropped and flagged for good.
    if (cap & full_q[wr_bank_q])
      overflow_d = 1'b1;

    if (wr_en) begin
      if (wr_row_q == LAST_ROW) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_row_d          = '0;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end

    // Set and clear can never hit the same bank: set needs it empty, clear needs it full.
    if (xfer) begin
      if (xfer_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_row_d          = '0;
      end else begin
        rd_row_d = rd_row_q + 1'b1;
      end
    end

    case (state_q)
      IDLE:    if (full_q[rd_bank_q]) state_d = STREAM;
      STREAM:  if (xfer_last)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_dly_q <= 1'b0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      rd_row_q    <= '0;
      full_q      <= '0;
      overflow_q  <= 1'b0;
      blk_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_dly_q <= ready_dly_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_row_q    <= wr_row_d;
      rd_row_q    <= rd_row_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      blk_done_q  <= blk_done_d;
    end
  end

  // Storage is deliberately not reset; the full flags decide what is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_bank_q][wr_row_q] <= bus.current_pixels;
  end

  assign bus.row_out_valid = (state_q == STREAM);
  assign bus.row_out       = bus.row_out_valid ? mem_q[rd_bank_q][rd_row_q] : '0;
  assign bus.row_out_idx   = rd_row_q;
  assign bus.row_out_last  = bus.row_out_valid & (rd_row_q == LAST_ROW);
  assign bus.blk_done      = blk_done_q;
  assign bus.overflow      = overflow_q;
  assign bus.curr_accept   = ~full_q[wr_bank_q];
endmodule
